// File: rtl/demux_pkg.sv
// Shared parameters and encodings for the buffered 1-to-2 demux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W_DEF  = 8;
  localparam int LVL_W      = 2;

  // Destination select carried on in_sel
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/fifo2.sv
// Two-entry queue: two entry registers, 1-bit read/write pointers, 2-bit level.
// Latency: a word pushed at edge N is at the head after edge N.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module fifo2
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_rd;
  logic              r_wr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_level == LVL_W'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd];
  // Defensive guards so the queue state can never over/underflow
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Entry storage, pointer wrap (1 -> 0 by inversion) and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/buf_demux_32.sv
// Buffered 1-to-2 demux: routes upstream words to port A or B through a 2-deep queue each.
// Latency: one cycle from upstream accept to x_valid; no combinational in-to-out path.
// Backpressure: in_ready follows only the selected queue's full flag, so a stalled port never blocks the other.
module buf_demux_32
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic [LVL_W-1:0]  a_level,
  output logic [LVL_W-1:0]  b_level,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  logic             w_a_full;
  logic             w_b_full;
  logic             w_a_empty;
  logic             w_b_empty;
  logic             w_sel_b;
  logic             w_accept;
  logic             w_a_push;
  logic             w_b_push;
  logic             w_a_pop;
  logic             w_b_pop;
  logic [CNT_W-1:0] r_a_count;
  logic [CNT_W-1:0] r_b_count;

  // Select decode; in_ready deliberately ignores a_ready/b_ready, so a full
  // queue refuses a word even in the cycle it is draining.
  assign w_sel_b  = (port_sel_e'(in_sel) == PORT_B);
  assign in_ready = w_sel_b ? ~w_b_full : ~w_a_full;
  assign w_accept = in_valid & in_ready;
  assign w_a_push = w_accept & ~w_sel_b;
  assign w_b_push = w_accept &  w_sel_b;

  assign a_valid  = ~w_a_empty;
  assign b_valid  = ~w_b_empty;
  assign w_a_pop  = a_valid & a_ready;
  assign w_b_pop  = b_valid & b_ready;
  assign a_count  = r_a_count;
  assign b_count  = r_b_count;

  fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_q_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_a_push),
    .pop   (w_a_pop),
    .din   (in_data),
    .dout  (a_data),
    .full  (w_a_full),
    .empty (w_a_empty),
    .level (a_level)
  );

  fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_q_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_b_push),
    .pop   (w_b_pop),
    .din   (in_data),
    .dout  (b_data),
    .full  (w_b_full),
    .empty (w_b_empty),
    .level (b_level)
  );

  // Delivered-word counters, free-running with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_a_pop) r_a_count <= r_a_count + CNT_W'(1);
      if (w_b_pop) r_b_count <= r_b_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_buf_demux_32.sv
// Self-checking bench for buf_demux_32 against a queue-based reference model.
// Latency: model predicts one-cycle accept-to-valid.
// Backpressure: randomized and directed stalls on both ports.
module tb_buf_demux_32;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [DW-1:0] a_data, b_data;
  logic [1:0]    a_level, b_level;
  logic [CW-1:0] a_count, b_count;

  always #5 clk = ~clk;

  buf_demux_32 #(.DATA_W(DW), .DEPTH(2), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_level  (a_level),
    .b_level  (b_level),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one queue per port plus delivered-word counts mod 256
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            cnt_a = 0;
  int            cnt_b = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic model_ready();
    return in_sel ? (qb.size() < 2) : (qa.size() < 2);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready()));
    chk({tag, ".a_valid"},  64'(a_valid),  64'(qa.size() != 0));
    chk({tag, ".b_valid"},  64'(b_valid),  64'(qb.size() != 0));
    if (qa.size() != 0) chk({tag, ".a_data"}, 64'(a_data), 64'(qa[0]));
    if (qb.size() != 0) chk({tag, ".b_data"}, 64'(b_data), 64'(qb[0]));
    chk({tag, ".a_level"},  64'(a_level),  64'(qa.size()));
    chk({tag, ".b_level"},  64'(b_level),  64'(qb.size()));
    chk({tag, ".a_count"},  64'(a_count),  64'(cnt_a));
    chk({tag, ".b_count"},  64'(b_count),  64'(cnt_b));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".a_valid"},  64'(a_valid),  64'd0);
    chk({tag, ".b_valid"},  64'(b_valid),  64'd0);
    chk({tag, ".a_data"},   64'(a_data),   64'd0);
    chk({tag, ".b_data"},   64'(b_data),   64'd0);
    chk({tag, ".a_level"},  64'(a_level),  64'd0);
    chk({tag, ".b_level"},  64'(b_level),  64'd0);
    chk({tag, ".a_count"},  64'(a_count),  64'd0);
    chk({tag, ".b_count"},  64'(b_count),  64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // Called at posedge+1 with inputs already driven; checks at negedge, then
  // advances the model across the next rising edge.
  task automatic cycle(input string tag, output logic acc);
    logic          pa, pb, s;
    logic [DW-1:0] d;
    @(negedge clk);
    check_outputs(tag);
    acc = in_valid && model_ready();
    s   = in_sel;
    d   = in_data;
    pa  = (qa.size() != 0) && a_ready;
    pb  = (qb.size() != 0) && b_ready;
    @(posedge clk);
    if (pa) begin void'(qa.pop_front()); cnt_a = (cnt_a + 1) % 256; end
    if (pb) begin void'(qb.pop_front()); cnt_b = (cnt_b + 1) % 256; end
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(tag, acc);
  endtask

  // Present one word and hold it until the model says it was taken
  task automatic send(input string tag, input logic sel, input logic [DW-1:0] d);
    logic acc;
    int   budget;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    budget   = 0;
    acc      = 1'b0;
    while (!acc && budget < 16) begin
      cycle(tag, acc);
      budget++;
    end
    if (!acc) chk({tag, ".accept_timeout"}, 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #3;
    model_clear();
    check_reset("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    #12;
    do_reset();

    // Single word to A
    a_ready = 1'b1;
    send("single", 1'b0, 32'h1234_5678);
    idle("single.out", 2);
    chk("single.a_count", 64'(a_count), 64'd1);
    chk("single.b_valid", 64'(b_valid), 64'd0);

    // Back-pressure and full on A, then independent B, then drain
    a_ready = 1'b0;
    send("bp.a0", 1'b0, 32'hA0);
    send("bp.a1", 1'b0, 32'hA1);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA2;
    cycle("bp.full", acc);
    chk("bp.in_ready_low", 64'(in_ready), 64'd0);
    chk("bp.a_level2", 64'(a_level), 64'd2);
    in_valid = 1'b0;
    send("indep.b0", 1'b1, 32'hB0);
    chk("indep.b_data", 64'(b_data), 64'hB0);
    chk("indep.a_level", 64'(a_level), 64'd2);
    a_ready = 1'b1;
    b_ready = 1'b1;
    send("bp.a2", 1'b0, 32'hA2);
    idle("bp.drain", 3);

    // Streaming 0..9 to A
    do_reset();
    a_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send("stream", 1'b0, DW'(i));
      chk("stream.lvl_le1", 64'(a_level <= 2'd1), 64'd1);
    end
    idle("stream.tail", 2);
    chk("stream.a_count", 64'(a_count), 64'd10);

    // Counter and pointer wrap on B
    do_reset();
    b_ready = 1'b1;
    for (int i = 0; i < 256; i++) send("wrap", 1'b1, DW'($urandom));
    idle("wrap.tail", 2);
    chk("wrap.b_count", 64'(b_count), 64'd0);

    // Mid-operation asynchronous reset
    a_ready = 1'b0;
    b_ready = 1'b0;
    send("mid.a", 1'b0, 32'hC0);
    send("mid.a", 1'b0, 32'hC1);
    send("mid.b", 1'b1, 32'hD0);
    idle("mid.hold", 1);
    chk("mid.a_level", 64'(a_level), 64'd2);
    chk("mid.b_level", 64'(b_level), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset("mid_rst");
    @(posedge clk);
    #1;
    // Word waiting at release must be taken on the first rising edge
    rst_n    = 1'b1;
    a_ready  = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hE0;
    cycle("post_rst", acc);
    chk("post_rst.accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    idle("post_rst.out", 2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      a_ready  = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 3) == 0);
      cycle("rand", acc);
    end
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    idle("rand.drain", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
